// File: rtl/welch_psd_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : welch_psd_accumulator_if
// Brief    : Config, sample-stream and PSD output stream bundle for one
//            Welch PSD averaging channel.
// Revision : 1.0
// ============================================================================
interface welch_psd_accumulator_if #(
    parameter int MAG_WIDTH  = 80,
    parameter int AVG_BITS   = 8,
    parameter int ACC_WIDTH  = MAG_WIDTH + AVG_BITS,
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] fft_size_m1;
    logic [AVG_BITS-1:0]   num_avg_m1;
    logic [3:0]            avg_shift;
    logic [MAG_WIDTH-1:0]  mag_sq;
    logic                  mag_sq_valid;
    logic                  fft_done;
    logic [ACC_WIDTH-1:0]  psd_data;
    logic                  psd_valid;
    logic                  psd_ready;
    logic                  psd_last;
    logic                  busy;
    logic                  run_done;
    logic                  frame_err;
    logic                  overrun;

    modport master (
        output start, fft_size_m1, num_avg_m1, avg_shift,
        output mag_sq, mag_sq_valid, fft_done, psd_ready,
        input  psd_data, psd_valid, psd_last, busy, run_done, frame_err, overrun
    );

    modport slave (
        input  start, fft_size_m1, num_avg_m1, avg_shift,
        input  mag_sq, mag_sq_valid, fft_done, psd_ready,
        output psd_data, psd_valid, psd_last, busy, run_done, frame_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/welch_psd_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : welch_psd_accumulator
// Brief    : Sums magnitude-squared bins over N frames in a RAM, then drains
//            the shifted averages as a valid/ready stream.
// Revision : 1.0
// ============================================================================
module welch_psd_accumulator #(
    parameter int MAG_WIDTH  = 80,
    parameter int AVG_BITS   = 8,
    parameter int ACC_WIDTH  = MAG_WIDTH + AVG_BITS,
    parameter int ADDR_WIDTH = 12
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    welch_psd_accumulator_if.slave  bus
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_cfg_size;
    logic [AVG_BITS-1:0]   r_cfg_navg;
    logic [3:0]            r_cfg_shift;
    logic [CNT_W-1:0]      r_bin_idx;
    logic [AVG_BITS-1:0]   r_frame;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  r_run_done;

    logic                  r_p1_v;
    logic [ADDR_WIDTH-1:0] r_p1_addr;
    logic [MAG_WIDTH-1:0]  r_p1_mag;
    logic                  r_p1_first;
    logic                  r_p2_v;
    logic [ADDR_WIDTH-1:0] r_p2_addr;
    logic [ACC_WIDTH-1:0]  r_p2_sum;

    logic [ACC_WIDTH-1:0]  r_ram [0:(1<<ADDR_WIDTH)-1];
    logic [ACC_WIDTH-1:0]  r_ram_q;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_all;
    logic                  r_rd_pend;
    logic                  r_rd_last;
    logic                  r_head_v;
    logic                  r_head_l;
    logic [ACC_WIDTH-1:0]  r_head_d;
    logic                  r_tail_v;
    logic                  r_tail_l;
    logic [ACC_WIDTH-1:0]  r_tail_d;

    logic                  w_start;
    logic                  w_bin_ok;
    logic                  w_bin_extra;
    logic [CNT_W-1:0]      w_bin_cnt;
    logic [CNT_W-1:0]      w_size_p1;
    logic                  w_frame_end;
    logic                  w_last_frame;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_used;
    logic [2:0]            w_cap;
    logic [ACC_WIDTH-1:0]  w_in_d;

    // A start landing on the run_done cycle belongs to the run just finished.
    assign w_start      = (r_state == S_IDLE) && bus.start && !r_run_done;
    assign w_size_p1    = {1'b0, r_cfg_size} + CNT_W'(1);
    assign w_bin_ok     = (r_state == S_ACCUM) && bus.mag_sq_valid && (r_bin_idx < w_size_p1);
    assign w_bin_extra  = (r_state == S_ACCUM) && bus.mag_sq_valid && (r_bin_idx >= w_size_p1);
    assign w_bin_cnt    = r_bin_idx + CNT_W'(w_bin_ok);
    assign w_frame_end  = (r_state == S_ACCUM) && bus.fft_done;
    assign w_last_frame = (r_frame == r_cfg_navg);

    assign w_pop   = r_head_v && bus.psd_ready;
    assign w_used  = {2'b00, r_head_v} + {2'b00, r_tail_v} + {2'b00, r_rd_pend};
    assign w_cap   = 3'd2 + {2'b00, w_pop};
    assign w_issue = (r_state == S_DRAIN) && !r_rd_all && (w_used < w_cap);

    assign w_rd_addr = (r_state == S_DRAIN) ? r_rd_addr : r_bin_idx[ADDR_WIDTH-1:0];
    assign w_sum     = r_p1_first ? ACC_WIDTH'(r_p1_mag)
                                  : r_ram_q + ACC_WIDTH'(r_p1_mag);
    assign w_in_d    = r_ram_q >> r_cfg_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_frame_end && w_last_frame) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && r_head_l) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_size  <= '0;
            r_cfg_navg  <= '0;
            r_cfg_shift <= '0;
            r_bin_idx   <= '0;
            r_frame     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_run_done  <= 1'b0;
        end else begin
            r_run_done <= w_pop && r_head_l;
            if (w_start) begin
                r_cfg_size  <= bus.fft_size_m1;
                r_cfg_navg  <= bus.num_avg_m1;
                r_cfg_shift <= bus.avg_shift;
                r_bin_idx   <= '0;
                r_frame     <= '0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end else if (r_state == S_ACCUM) begin
                // A bin coincident with fft_done is counted before the length check.
                if (w_frame_end) begin
                    r_bin_idx <= '0;
                    if (!w_last_frame) r_frame <= r_frame + AVG_BITS'(1);
                    if (w_bin_cnt != w_size_p1) r_frame_err <= 1'b1;
                end else if (w_bin_ok) begin
                    r_bin_idx <= w_bin_cnt;
                end
                if (w_bin_extra) r_frame_err <= 1'b1;
            end else if ((r_state == S_FLUSH || r_state == S_DRAIN) && bus.mag_sq_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_v     <= 1'b0;
            r_p1_addr  <= '0;
            r_p1_mag   <= '0;
            r_p1_first <= 1'b0;
            r_p2_v     <= 1'b0;
            r_p2_addr  <= '0;
            r_p2_sum   <= '0;
        end else begin
            r_p1_v     <= w_bin_ok;
            r_p1_addr  <= r_bin_idx[ADDR_WIDTH-1:0];
            r_p1_mag   <= bus.mag_sq;
            r_p1_first <= (r_frame == '0);
            r_p2_v     <= r_p1_v;
            r_p2_addr  <= r_p1_addr;
            r_p2_sum   <= w_sum;
        end
    end

    // Frame 0 overwrites every bin, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (r_p2_v) r_ram[r_p2_addr] <= r_p2_sum;
        r_ram_q <= r_ram[w_rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_last <= 1'b0;
        end else if (w_start) begin
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            r_rd_last <= w_issue && (r_rd_addr == r_cfg_size);
            if (w_issue) begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                if (r_rd_addr == r_cfg_size) r_rd_all <= 1'b1;
            end
        end
    end

    // Head is the output register; tail catches the beat already in flight
    // from the RAM when the head stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_v <= 1'b0;
            r_head_l <= 1'b0;
            r_head_d <= '0;
            r_tail_v <= 1'b0;
            r_tail_l <= 1'b0;
            r_tail_d <= '0;
        end else if (w_pop) begin
            if (r_tail_v) begin
                r_head_v <= 1'b1;
                r_head_l <= r_tail_l;
                r_head_d <= r_tail_d;
                r_tail_v <= r_rd_pend;
                if (r_rd_pend) begin
                    r_tail_l <= r_rd_last;
                    r_tail_d <= w_in_d;
                end
            end else begin
                r_head_v <= r_rd_pend;
                if (r_rd_pend) begin
                    r_head_l <= r_rd_last;
                    r_head_d <= w_in_d;
                end
            end
        end else if (r_rd_pend) begin
            if (!r_head_v) begin
                r_head_v <= 1'b1;
                r_head_l <= r_rd_last;
                r_head_d <= w_in_d;
            end else begin
                r_tail_v <= 1'b1;
                r_tail_l <= r_rd_last;
                r_tail_d <= w_in_d;
            end
        end
    end

    assign bus.psd_data  = r_head_d;
    assign bus.psd_valid = r_head_v;
    assign bus.psd_last  = r_head_l;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.run_done  = r_run_done;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
